// File: rtl/npc_pc.sv
// Fetch-stage program counter with D-stage next-PC selection and a saturating redirect counter.
// Optional macro NPC_ALIGN_CHECK_EN adds AlignErr and word-aligns misaligned jr targets.
module npc_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       NPC_Op,
    input  logic             CMP_Output,
    input  logic [31:0]      D_PC,
    input  logic [15:0]      Imm16,
    input  logic [25:0]      Index26,
    input  logic [31:0]      RegTarget,
    output logic [31:0]      F_PC,
    output logic [31:0]      D_PC8,
    output logic             Redirect,
`ifdef NPC_ALIGN_CHECK_EN
    output logic             AlignErr,
`endif
    output logic [CNT_W-1:0] RedirectCnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] j_pc;
    logic [31:0] jr_pc;
    logic [31:0] next_pc;

    assign seq_pc = F_PC + 32'd4;
    assign br_pc  = D_PC + 32'd4 + {{14{Imm16[15]}}, Imm16, 2'b00};
    assign j_pc   = {D_PC[31:28], Index26, 2'b00};
    assign D_PC8  = D_PC + 32'd8;

`ifdef NPC_ALIGN_CHECK_EN
    assign AlignErr = (NPC_Op == 3'd3) && (RegTarget[1:0] != 2'b00);
    assign jr_pc    = AlignErr ? {RegTarget[31:2], 2'b00} : RegTarget;
`else
    assign jr_pc    = RegTarget;
`endif

    always_comb begin
        next_pc  = seq_pc;
        Redirect = 1'b0;
        case (NPC_Op)
            3'd1: begin
                if (CMP_Output) begin
                    next_pc  = br_pc;
                    Redirect = 1'b1;
                end
            end
            3'd2: begin
                next_pc  = j_pc;
                Redirect = 1'b1;
            end
            3'd3: begin
                next_pc  = jr_pc;
                Redirect = 1'b1;
            end
            default: begin
                next_pc  = seq_pc;
                Redirect = 1'b0;
            end
        endcase
    end

    // Stall ignores the D-stage inputs entirely; that instruction re-presents next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            F_PC        <= RESET_PC;
            RedirectCnt <= '0;
        end else if (!stall) begin
            F_PC <= next_pc;
            if (Redirect && !(&RedirectCnt))
                RedirectCnt <= RedirectCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_npc_pc.sv
// Directed bench for npc_pc: expected PC/count pushed at drive time, popped and checked after each edge.
module tb_npc_pc;

    localparam int CW = 2;

    logic          clk;
    logic          reset;
    logic          stall;
    logic [2:0]    NPC_Op;
    logic          CMP_Output;
    logic [31:0]   D_PC;
    logic [15:0]   Imm16;
    logic [25:0]   Index26;
    logic [31:0]   RegTarget;
    logic [31:0]   F_PC;
    logic [31:0]   D_PC8;
    logic          Redirect;
    logic [CW-1:0] RedirectCnt;
`ifdef NPC_ALIGN_CHECK_EN
    logic          AlignErr;
`endif

    npc_pc #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .NPC_Op(NPC_Op),
        .CMP_Output(CMP_Output),
        .D_PC(D_PC),
        .Imm16(Imm16),
        .Index26(Index26),
        .RegTarget(RegTarget),
        .F_PC(F_PC),
        .D_PC8(D_PC8),
        .Redirect(Redirect),
`ifdef NPC_ALIGN_CHECK_EN
        .AlignErr(AlignErr),
`endif
        .RedirectCnt(RedirectCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [31:0]   pc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [31:0]   pc_m;
    logic [CW-1:0] cnt_m;

    task automatic step(input string tag, input logic rst, input logic st, input logic [2:0] op,
                        input logic cmp, input logic [31:0] dpc, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] rt);
        logic [31:0] nxt;
        logic        redir;
        exp_t        e;
        exp_t        got;
        reset = rst; stall = st; NPC_Op = op; CMP_Output = cmp;
        D_PC = dpc; Imm16 = imm; Index26 = idx; RegTarget = rt;
        nxt   = pc_m + 32'd4;
        redir = 1'b0;
        if (op == 3'd1 && cmp) begin
            nxt = dpc + 32'd4 + ($signed({{16{imm[15]}}, imm}) * 4);
            redir = 1'b1;
        end else if (op == 3'd2) begin
            nxt = (dpc & 32'hF000_0000) | ({6'd0, idx} * 4);
            redir = 1'b1;
        end else if (op == 3'd3) begin
            nxt = rt;
`ifdef NPC_ALIGN_CHECK_EN
            nxt = rt & 32'hFFFF_FFFC;
`endif
            redir = 1'b1;
        end
        #1;
        checks++;
        assert (Redirect === redir) else begin
            errors++;
            $error("FAIL %s.redirect observed=%b expected=%b", tag, Redirect, redir);
        end
        checks++;
        assert (D_PC8 === dpc + 32'd8) else begin
            errors++;
            $error("FAIL %s.dpc8 observed=%h expected=%h", tag, D_PC8, dpc + 32'd8);
        end
`ifdef NPC_ALIGN_CHECK_EN
        checks++;
        assert (AlignErr === (op == 3'd3 && rt[1:0] != 2'b00)) else begin
            errors++;
            $error("FAIL %s.alignerr observed=%b expected=%b", tag, AlignErr, (op == 3'd3 && rt[1:0] != 2'b00));
        end
`endif
        if (!rst) begin
            pc_m  = 32'h0000_3000;
            cnt_m = '0;
        end else if (!st) begin
            pc_m = nxt;
            if (redir && cnt_m != {CW{1'b1}}) cnt_m = cnt_m + 1'b1;
        end
        e.tag = tag; e.pc = pc_m; e.cnt = cnt_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (F_PC === got.pc) else begin
            errors++;
            $error("FAIL %s.f_pc observed=%h expected=%h", got.tag, F_PC, got.pc);
        end
        checks++;
        assert (RedirectCnt === got.cnt) else begin
            errors++;
            $error("FAIL %s.cnt observed=%0d expected=%0d", got.tag, RedirectCnt, got.cnt);
        end
    endtask

    initial begin
        pc_m  = 32'h0;
        cnt_m = '0;
        @(negedge clk);
        step("rst0",     1'b0, 1'b0, 3'd0, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0);
        step("rst1",     1'b0, 1'b1, 3'd2, 1'b0, 32'h0,         16'h0,    26'h0,       32'h0);
        step("seq0",     1'b1, 1'b0, 3'd0, 1'b0, 32'h3000,      16'h0,    26'h0,       32'h0);
        step("seq1",     1'b1, 1'b0, 3'd5, 1'b1, 32'h3004,      16'h0,    26'h0,       32'h0);
        step("br_tk",    1'b1, 1'b0, 3'd1, 1'b1, 32'h3004,      16'hFFFE, 26'h0,       32'h0);
        step("br_nt",    1'b1, 1'b0, 3'd1, 1'b0, 32'h3004,      16'hFFFE, 26'h0,       32'h0);
        step("jal",      1'b1, 1'b0, 3'd2, 1'b0, 32'h3010,      16'h0,    26'h0000C40, 32'h0);
        step("stall",    1'b1, 1'b1, 3'd3, 1'b0, 32'h3020,      16'h0,    26'h0,       32'h4000);
        step("unstall",  1'b1, 1'b0, 3'd3, 1'b0, 32'h3020,      16'h0,    26'h0,       32'h4000);
        step("jr_top",   1'b1, 1'b0, 3'd3, 1'b0, 32'h4000,      16'h0,    26'h0,       32'hFFFF_FFFC);
        step("wrap",     1'b1, 1'b0, 3'd0, 1'b0, 32'h4004,      16'h0,    26'h0,       32'h0);
        step("rst_mid",  1'b0, 1'b0, 3'd2, 1'b0, 32'h3010,      16'h0,    26'h0000C40, 32'h0);
        step("sat1",     1'b1, 1'b0, 3'd1, 1'b1, 32'hFFFF_FFF8, 16'h0001, 26'h0,       32'h0);
        step("sat2",     1'b1, 1'b0, 3'd2, 1'b0, 32'hA000_0000, 16'h0,    26'h3FFFFFF, 32'h0);
        step("sat3",     1'b1, 1'b0, 3'd3, 1'b0, 32'h0,         16'h0,    26'h0,       32'h1234_5678);
        step("sat4",     1'b1, 1'b0, 3'd1, 1'b1, 32'h7FFF_FFF0, 16'h7FFF, 26'h0,       32'h0);
        step("sat5",     1'b1, 1'b0, 3'd2, 1'b0, 32'h5000_0000, 16'h0,    26'h0000001, 32'h0);
        step("sat_seq",  1'b1, 1'b0, 3'd1, 1'b0, 32'h0,         16'h0010, 26'h0,       32'h0);
        step("align",    1'b1, 1'b0, 3'd3, 1'b0, 32'h3000,      16'h0,    26'h0,       32'h3007);
        step("post",     1'b1, 1'b0, 3'd0, 1'b0, 32'h3000,      16'h0,    26'h0,       32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_pc.md
# npc_pc

Fetch-stage program counter with next-PC selection for the five-stage pipeline. Consumes the D-stage comparator result (`CMP_Output`) together with the D-stage instruction's jump/branch fields, and registers the next fetch address. Branches and jumps resolve in D with a one-instruction delay slot: the instruction already in F is never flushed. A saturating counter records taken redirects for performance checks.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: PC value loaded on reset.
- `CNT_W`, default 32: width of the redirect counter.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-low; sampled on the rising edge of `clk`.
- `stall`  in  1  — from the hazard unit; holds the PC.
- `NPC_Op`  in  3  — 0 = sequential, 1 = conditional branch, 2 = j/jal, 3 = jr/jalr, 4–7 = sequential.
- `CMP_Output`  in  1  — branch-taken result from the D-stage comparator.
- `D_PC`  in  32  — PC of the instruction in D.
- `Imm16`  in  16  — branch offset field of the D instruction.
- `Index26`  in  26  — jump index field of the D instruction.
- `RegTarget`  in  32  — forwarded rs value for jr.
- `F_PC`  out  32  — current fetch address (registered).
- `D_PC8`  out  32  — `D_PC + 8`, the link value for jal/jalr.
- `Redirect`  out  1  — combinational; next PC is not `F_PC + 4`.
- `RedirectCnt`  out  `CNT_W`  — count of committed redirects.

## Operation
- Candidate next PC, all arithmetic mod 2^32:
  - sequential: `F_PC + 4`
  - branch taken: `D_PC + 4 + (sign_ext(Imm16) << 2)`
  - j/jal: `{D_PC[31:28], Index26, 2'b00}`
  - jr: `RegTarget`
- `NPC_Op = 1` with `CMP_Output = 0` selects sequential.
- `Redirect` is high when the selected source is not sequential: op 1 with `CMP_Output = 1`, op 2, or op 3.
- On a rising edge with `reset = 0`:
  - `F_PC <= RESET_PC`
  - `RedirectCnt <= 0`
- On a rising edge with `reset = 1` and `stall = 1`:
  - `F_PC` and `RedirectCnt` hold.
  - `NPC_Op` and the other D-stage inputs are ignored, because the D instruction re-presents next cycle.
- On a rising edge with `reset = 1` and `stall = 0`:
  - `F_PC <=` the selected candidate.
  - If `Redirect = 1`, `RedirectCnt` increments, saturating at all-ones.
- Delay slot: when D holds a branch, F holds `D_PC + 4`. That instruction proceeds normally and the target is fetched next.
- `D_PC8` is purely combinational from `D_PC`, with no gating.
- No internal state beyond `F_PC` and `RedirectCnt`.

## Timing
- `F_PC` changes only on the rising edge of `clk`; it equals `RESET_PC` from the first edge with `reset` low.
- Branch/jump latency: resolved in D in cycle N; the target appears on `F_PC` in cycle N+1 (one edge).
- `reset` takes precedence over `stall`. Asserting `reset` mid-redirect discards the redirect, and the counter clears that edge.
- Wrap-around:
  - `F_PC = 32'hFFFF_FFFC`, sequential → `32'h0000_0000`.
  - A branch offset that overflows wraps silently.
- `Redirect` and `D_PC8` settle combinationally within the cycle; they have no reset value of their own.

## Configuration
- `NPC_ALIGN_CHECK_EN` defined:
  - Adds output `AlignErr` (1 bit, combinational), high when `NPC_Op = 3` and `RegTarget[1:0] != 0`.
  - While `AlignErr` is high, the PC loads `{RegTarget[31:2], 2'b00}`.
- `NPC_ALIGN_CHECK_EN` not defined: the `AlignErr` port is absent and jr loads `RegTarget` unmodified.

## Test plan
- Reset and sequential fetch: hold `reset = 0` for 2 edges, then release → `F_PC = 32'h3000`, then `32'h3004`, `32'h3008`; `RedirectCnt = 0`.
- Branch taken vs not taken: `D_PC = 32'h3004`, `NPC_Op = 1`, `Imm16 = 16'hFFFE`.
  - `CMP_Output = 1` → next `F_PC = 32'h3000`, `RedirectCnt = 1`.
  - `CMP_Output = 0` → next `F_PC = F_PC + 4`, count unchanged.
- Jump and link: `D_PC = 32'h3010`, `NPC_Op = 2`, `Index26 = 26'h0000C40` → next `F_PC = 32'h0000_3100`; `D_PC8 = 32'h3018`.
- Stall precedence: `stall = 1` with `NPC_Op = 3`, `RegTarget = 32'h4000` → `F_PC` and `RedirectCnt` hold. Deassert `stall` → `F_PC = 32'h4000`.
- Wrap and saturation:
  - Force `F_PC` to `32'hFFFF_FFFC` via jr → next sequential `F_PC = 0`.
  - With `CNT_W = 2`, five redirects → `RedirectCnt = 3`.
- Alignment (macro defined): jr with `RegTarget = 32'h3007` → `AlignErr = 1` and next `F_PC = 32'h3004`.
